pin_controller: RTL

PIN_CONTROLLER -- requirements
Module: pin_controller

---
 rtl/meco_pkg.sv | 32 +++
 rtl/pin_sampler.sv | 55 +++++
 rtl/pin_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/meco_pkg.sv
// meco_pkg -- shared definitions for the pin controller slice.
//   Register indices on the command bus, MODE encodings, controller FSM
//   state encoding and the command word struct.
package meco_pkg;

   localparam logic [2:0] REG_MODE   = 3'd0;
   localparam logic [2:0] REG_HIGH_T = 3'd1;
   localparam logic [2:0] REG_LOW_T  = 3'd2;
   localparam logic [2:0] REG_NCYC   = 3'd3;
   localparam logic [2:0] REG_START  = 3'd4;
   localparam logic [2:0] REG_STOP   = 3'd5;
   localparam logic [2:0] REG_SDIV   = 3'd6;

   typedef enum logic [1:0] {
      MODE_LOW    = 2'd0,
      MODE_HIGH   = 2'd1,
      MODE_SQUARE = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_e;

   typedef struct packed {
      logic [3:0]  pin;
      logic [2:0]  idx;
      logic [15:0] data;
   } cmd_t;

endpackage

// File: rtl/pin_sampler.sv
// pin_sampler -- input sampler for one pin (built only with PIN_SAMPLE_EN).
//   clk, reset   : system clock, synchronous active-high reset
//   restart      : restart divider and bit counter (START write)
//   sdiv         : sample divider, one sample every max(sdiv,1) cycles
//   pin_in       : raw asynchronous pin level
//   sample_data  : last 16 samples, first-taken sample ends in bit 0
//   sample_valid : one-cycle pulse when a full set of 16 samples is present
module pin_sampler
   import meco_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic [CNT_W-1:0] sdiv,
   input  logic             pin_in,
   output logic [15:0]      sample_data,
   output logic             sample_valid
);

   logic [1:0]       sync_pipe;
   logic [CNT_W-1:0] div_cnt;
   logic [3:0]       bit_cnt;
   logic             div_last;

   // sdiv of 0 behaves like 1: sample every cycle
   assign div_last = (sdiv == '0) || (div_cnt >= sdiv - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_pipe    <= '0;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         sample_data  <= '0;
         sample_valid <= 1'b0;
      end else begin
         sync_pipe    <= {sync_pipe[0], pin_in};
         sample_valid <= 1'b0;
         if (restart) begin
            div_cnt <= '0;
            bit_cnt <= '0;
         end else if (div_last) begin
            div_cnt     <= '0;
            // shift right so the oldest sample of a set lands in bit 0
            sample_data <= {sync_pipe[1], sample_data[15:1]};
            bit_cnt     <= bit_cnt + 4'd1;   // modulo-16 set counter
            if (bit_cnt == 4'd15) sample_valid <= 1'b1;
         end else begin
            div_cnt <= div_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/pin_controller.sv
// pin_controller -- single-pin waveform generator on a shared command bus.
//   clk, reset          : system clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready low only during reset)
//   cmd_pin/reg/data    : target pin, register index, write data
//   pin_out             : driven pin level
//   busy                : waveform running (state not IDLE)
//   done                : one-cycle pulse at the end of a finite run
//   pin_in              : raw pin level (used only by the sampler)
//   sample_data/valid   : packed samples and new-data pulse
// Optional feature: define PIN_SAMPLE_EN to build the input sampler;
// otherwise the sample outputs are tied to 0 and SDIV writes are ignored.
module pin_controller
   import meco_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int PIN_ID = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_pin,
   input  logic [2:0]  cmd_reg,
   input  logic [15:0] cmd_data,
   output logic        pin_out,
   output logic        busy,
   output logic        done,
   input  logic        pin_in,
   output logic [15:0] sample_data,
   output logic        sample_valid
);

   function automatic logic [CNT_W-1:0] max1(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   cmd_t             cmd;
   logic             wr, wr_start, wr_stop;
   mode_e            mode_q;
   logic [CNT_W-1:0] high_t_q, low_t_q, ncyc_q;
   state_e           state;
   logic [CNT_W-1:0] cnt;       // cycles left in current phase
   logic [CNT_W-1:0] rem;       // periods left in a finite run
   logic             forever_q; // run started with NCYC = 0

   assign cmd       = '{pin: cmd_pin, idx: cmd_reg, data: cmd_data};
   assign cmd_ready = ~reset;
   assign wr        = cmd_valid && cmd_ready && (cmd.pin == 4'(PIN_ID));
   assign wr_start  = wr && (cmd.idx == REG_START);
   assign wr_stop   = wr && (cmd.idx == REG_STOP);
   assign busy      = (state != IDLE);

`ifdef PIN_SAMPLE_EN
   logic [CNT_W-1:0] sdiv_q;
`endif

   // register file
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q   <= MODE_LOW;
         high_t_q <= '0;
         low_t_q  <= '0;
         ncyc_q   <= '0;
`ifdef PIN_SAMPLE_EN
         sdiv_q   <= '0;
`endif
      end else if (wr) begin
         case (cmd.idx)
            REG_MODE:   mode_q   <= mode_e'(cmd.data[1:0]);
            REG_HIGH_T: high_t_q <= CNT_W'(cmd.data);
            REG_LOW_T:  low_t_q  <= CNT_W'(cmd.data);
            REG_NCYC:   ncyc_q   <= CNT_W'(cmd.data);
`ifdef PIN_SAMPLE_EN
            REG_SDIV:   sdiv_q   <= CNT_W'(cmd.data);
`endif
            default: ;
         endcase
      end
   end

   // waveform FSM; STOP is checked first so it wins over START
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pin_out   <= 1'b0;
         done      <= 1'b0;
         cnt       <= '0;
         rem       <= '0;
         forever_q <= 1'b0;
      end else begin
         done <= 1'b0;
         if (wr_stop) begin
            state   <= IDLE;
            pin_out <= 1'b0;
            cnt     <= '0;
         end else if (wr_start) begin
            rem       <= ncyc_q;
            forever_q <= (ncyc_q == '0);
            case (mode_q)
               MODE_SQUARE: begin
                  state   <= HIGH;
                  pin_out <= 1'b1;
                  cnt     <= max1(high_t_q);
               end
               MODE_HIGH: begin
                  state   <= IDLE;
                  pin_out <= 1'b1;
                  cnt     <= '0;
               end
               default: begin
                  state   <= IDLE;
                  pin_out <= 1'b0;
                  cnt     <= '0;
               end
            endcase
         end else begin
            case (state)
               HIGH: begin
                  if (cnt <= CNT_W'(1)) begin
                     state   <= LOW;
                     pin_out <= 1'b0;
                     cnt     <= max1(low_t_q);
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               LOW: begin
                  if (cnt > CNT_W'(1)) begin
                     cnt <= cnt - CNT_W'(1);
                  end else if (forever_q || rem > CNT_W'(1)) begin
                     if (!forever_q) rem <= rem - CNT_W'(1);
                     state   <= HIGH;
                     pin_out <= 1'b1;
                     cnt     <= max1(high_t_q);
                  end else begin
                     rem     <= '0;
                     cnt     <= '0;
                     state   <= IDLE;
                     pin_out <= 1'b0;
                     done    <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef PIN_SAMPLE_EN
   pin_sampler #(.CNT_W(CNT_W)) u_sampler (
      .clk          (clk),
      .reset        (reset),
      .restart      (wr_start),
      .sdiv         (sdiv_q),
      .pin_in       (pin_in),
      .sample_data  (sample_data),
      .sample_valid (sample_valid)
   );
`else
   logic unused_pin_in;
   assign unused_pin_in = pin_in;
   assign sample_data   = '0;
   assign sample_valid  = 1'b0;
`endif

endmodule
